// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, one outstanding imem request, small decode FIFO.
// Optional macro IFU_MISALIGN_TRAP_EN adds fetch_misalign and a sticky HALT state.
module instr_fetch_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7
`ifdef IFU_MISALIGN_TRAP_EN
    ,
    output logic            fetch_misalign
`endif
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        StReq,
        StWait,
        StDrop
`ifdef IFU_MISALIGN_TRAP_EN
        ,
        StHalt
`endif
    } state_e;

    state_e           state;
    logic [XLEN-1:0]  pc;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [XLEN+31:0] fifo_mem [BUF_DEPTH];
    logic             redirect_take;
    logic [XLEN-1:0]  redirect_target;
    logic             push;
    logic             pop;

    assign imem_req   = (state == StReq) && (count < CNT_W'(BUF_DEPTH)) && !rst;
    assign imem_addr  = pc;
    assign inst_valid = (count != '0);
    assign {inst_pc, inst} = fifo_mem[rd_ptr];
    assign opcode     = inst[6:0];
    assign funct3     = inst[14:12];
    assign funct7     = inst[31:25];

`ifdef IFU_MISALIGN_TRAP_EN
    logic redirect_bad;
    assign redirect_take = redirect_en && (state != StHalt);
    assign redirect_bad  = (redirect_pc[1:0] != 2'b00);
`else
    assign redirect_take = redirect_en;
`endif
    assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

    // A redirect cancels any same-cycle push or pop.
    assign push = (state == StWait) && imem_rvalid && !redirect_take;
    assign pop  = inst_valid && inst_ready && !redirect_take;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= StReq;
            pc     <= RESET_PC;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
`ifdef IFU_MISALIGN_TRAP_EN
            fetch_misalign <= 1'b0;
`endif
        end else if (redirect_take) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
`ifdef IFU_MISALIGN_TRAP_EN
            if (redirect_bad) begin
                state          <= StHalt;
                fetch_misalign <= 1'b1;
            end else
`endif
            begin
                pc <= redirect_target;
                // An issued or in-flight request must be drained before refetching.
                case (state)
                    StReq:   state <= imem_req ? StDrop : StReq;
                    default: state <= imem_rvalid ? StReq : StDrop;
                endcase
            end
        end else begin
            case (state)
                StReq: begin
                    if (imem_req) state <= StWait;
                end
                StWait: begin
                    if (imem_rvalid) begin
                        state <= StReq;
                        pc    <= pc + XLEN'(4);
                    end
                end
                StDrop: begin
                    if (imem_rvalid) state <= StReq;
                end
                default: state <= state;
            endcase
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) fifo_mem[wr_ptr] <= {pc, imem_rdata};
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory responder with latency k and an expected-instruction queue.
// Build with IFU_MISALIGN_TRAP_EN defined to exercise the trap variant.
module tb_instr_fetch_unit;
    localparam int unsigned XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0;
    localparam int unsigned BUF_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
`ifdef IFU_MISALIGN_TRAP_EN
    logic        fetch_misalign;
`endif

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .XLEN      (XLEN),
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7)
`ifdef IFU_MISALIGN_TRAP_EN
        ,
        .fetch_misalign (fetch_misalign)
`endif
    );

    int checks = 0;
    int failures = 0;
    int pops = 0;

    // Scoreboard entries are {pc, word}.
    logic [63:0] exp_q[$];
    bit          pend = 0;
    bit          live = 0;
    bit          halted = 0;
    int          due = 0;
    int          cyc = 0;
    int          k = 1;
    logic [31:0] paddr = '0;
    logic [31:0] exp_pc = RESET_PC;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0050_0093 + (a << 7);
    endfunction

    // One clock cycle: drive the memory response, score outputs, advance the model.
    task automatic cycle();
        bit          red;
        bit          exp_req;
        logic [63:0] head;
        logic [31:0] w;
        if (!rst && pend && due == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(paddr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        exp_req = !rst && !halted && !pend && (exp_q.size() < BUF_DEPTH);
        checks++;
        if (imem_req !== exp_req) begin
            failures++;
            $display("FAIL sb_imem_req cyc=%0d got=%b exp=%b", cyc, imem_req, exp_req);
        end
        if (exp_req) begin
            checks++;
            if (imem_addr !== exp_pc) begin
                failures++;
                $display("FAIL sb_imem_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, exp_pc);
            end
        end
        checks++;
        if (inst_valid !== (exp_q.size() != 0)) begin
            failures++;
            $display("FAIL sb_inst_valid cyc=%0d got=%b exp=%b", cyc, inst_valid, exp_q.size() != 0);
        end
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            w    = head[31:0];
            checks++;
            if (inst !== w || inst_pc !== head[63:32] || opcode !== w[6:0] ||
                funct3 !== w[14:12] || funct7 !== w[31:25]) begin
                failures++;
                $display("FAIL sb_head cyc=%0d got pc=%h inst=%h op=%h f3=%h f7=%h exp pc=%h inst=%h",
                         cyc, inst_pc, inst, opcode, funct3, funct7, head[63:32], w);
            end
        end
        red = redirect_en && !rst && !halted;
        if (rst) begin
            exp_q.delete();
            pend   = 0;
            live   = 0;
            halted = 0;
            exp_pc = RESET_PC;
        end else begin
            if (exp_q.size() != 0 && inst_ready && !red) begin
                void'(exp_q.pop_front());
                pops++;
            end
            if (imem_rvalid) begin
                pend = 0;
                if (live && !red && !halted) begin
                    exp_q.push_back({paddr, mem_word(paddr)});
                    exp_pc = exp_pc + 32'd4;
                end
            end
            if (exp_req) begin
                pend  = 1;
                live  = 1;
                due   = cyc + k;
                paddr = exp_pc;
            end
            if (red) begin
                exp_q.delete();
                live = 0;
`ifdef IFU_MISALIGN_TRAP_EN
                if (redirect_pc[1:0] != 2'b00) halted = 1;
                else exp_pc = redirect_pc & ~32'h3;
`else
                exp_pc = redirect_pc & ~32'h3;
`endif
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        redirect_en = 1'b0;
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        k = 1;
        inst_ready = 1'b1;
        rst = 1'b1;
        cycle();
        cycle();
        checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== RESET_PC) begin
            failures++;
            $display("FAIL reset_state got req=%b valid=%b addr=%h exp 0 0 %h",
                     imem_req, inst_valid, imem_addr, RESET_PC);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL first_req got req=%b addr=%h exp 1 00000000", imem_req, imem_addr);
        end
        cycle();
        cycle();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'h00500093 ||
            opcode !== 7'b0010011 || funct3 !== 3'b000) begin
            failures++;
            $display("FAIL first_inst got v=%b pc=%h inst=%h op=%b f3=%b exp 1 0 00500093 0010011 000",
                     inst_valid, inst_pc, inst, opcode, funct3);
        end
        repeat (4) cycle();
    endtask

    task automatic test_backpressure();
        k = 1;
        inst_ready = 1'b0;
        do_reset();
        repeat (4) cycle();
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h8 || inst_pc !== 32'h0) begin
            failures++;
            $display("FAIL bp_full got req=%b addr=%h pc=%h exp 0 8 0", imem_req, imem_addr, inst_pc);
        end
        repeat (2) cycle();
        checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold got req=%b valid=%b exp 0 1", imem_req, inst_valid);
        end
        inst_ready = 1'b1;
        cycle();
        checks++;
        if (inst_pc !== 32'h4 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            failures++;
            $display("FAIL bp_release got pc=%h req=%b addr=%h exp 4 1 8", inst_pc, imem_req, imem_addr);
        end
        repeat (6) cycle();
    endtask

    task automatic test_redirect_wait();
        int n;
        k = 3;
        inst_ready = 1'b1;
        do_reset();
        n = 0;
        while (!(imem_req === 1'b1 && imem_addr === 32'h8) && n < 50) begin
            cycle();
            n++;
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL rw_reach8 got timeout exp request at 00000008");
        end
        cycle();
        redirect_en = 1'b1;
        redirect_pc = 32'h40;
        cycle();
        redirect_en = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL rw_flush got valid=%b req=%b exp 0 0", inst_valid, imem_req);
        end
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            cycle();
            n++;
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40 || n < 1) begin
            failures++;
            $display("FAIL rw_target got req=%b addr=%h wait=%0d exp 1 40 >=1", imem_req, imem_addr, n);
        end
        repeat (10) cycle();
    endtask

    task automatic test_coincident();
        k = 1;
        inst_ready = 1'b0;
        do_reset();
        repeat (3) cycle();
        checks++;
        if (inst_valid !== 1'b1 || !pend || due != cyc) begin
            failures++;
            $display("FAIL co_setup got valid=%b pend=%b exp 1 1", inst_valid, pend);
        end
        inst_ready  = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = 32'h80;
        cycle();
        redirect_en = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h80) begin
            failures++;
            $display("FAIL co_result got valid=%b req=%b addr=%h exp 0 1 80", inst_valid, imem_req, imem_addr);
        end
        repeat (6) cycle();
    endtask

    task automatic test_reset_mid_wait();
        k = 3;
        inst_ready = 1'b0;
        do_reset();
        repeat (5) cycle();
        checks++;
        if (inst_valid !== 1'b1 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL rm_setup got valid=%b req=%b exp 1 0", inst_valid, imem_req);
        end
        rst = 1'b1;
        cycle();
        checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== RESET_PC) begin
            failures++;
            $display("FAIL rm_reset got valid=%b req=%b addr=%h exp 0 0 %h",
                     inst_valid, imem_req, imem_addr, RESET_PC);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            failures++;
            $display("FAIL rm_resume got req=%b addr=%h exp 1 %h", imem_req, imem_addr, RESET_PC);
        end
        inst_ready = 1'b1;
        repeat (10) cycle();
    endtask

    task automatic test_misalign();
        int n;
        k = 1;
        inst_ready = 1'b1;
        do_reset();
        repeat (3) cycle();
        redirect_en = 1'b1;
        redirect_pc = 32'h42;
        cycle();
        redirect_en = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
        repeat (3) cycle();
        redirect_en = 1'b1;
        redirect_pc = 32'h100;
        cycle();
        redirect_en = 1'b0;
        repeat (3) cycle();
        checks++;
        if (fetch_misalign !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL ma_halt got mis=%b req=%b valid=%b exp 1 0 0", fetch_misalign, imem_req, inst_valid);
        end
        do_reset();
        #1;
        checks++;
        if (fetch_misalign !== 1'b0 || imem_req !== 1'b1) begin
            failures++;
            $display("FAIL ma_clear got mis=%b req=%b exp 0 1", fetch_misalign, imem_req);
        end
`else
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            cycle();
            n++;
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            failures++;
            $display("FAIL ma_align got req=%b addr=%h exp 1 40", imem_req, imem_addr);
        end
`endif
        repeat (6) cycle();
    endtask

    task automatic test_random();
        int pops_before;
        do_reset();
        pops_before = pops;
        for (int i = 0; i < 400; i++) begin
            inst_ready  = ($urandom_range(0, 3) != 0);
            k           = $urandom_range(1, 4);
            redirect_en = (i == 200) || ($urandom_range(0, 15) == 0);
            redirect_pc = (i == 200) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_0FFC);
            cycle();
        end
        redirect_en = 1'b0;
        inst_ready  = 1'b1;
        repeat (10) cycle();
        checks++;
        if (pops - pops_before < 20) begin
            failures++;
            $display("FAIL rnd_progress got pops=%0d exp >=20", pops - pops_before);
        end
    endtask

    initial begin
        rst         = 1'b1;
        redirect_en = 1'b0;
        redirect_pc = '0;
        inst_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_backpressure();
        test_redirect_wait();
        test_coincident();
        test_reset_mid_wait();
        test_misalign();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
